// File: rtl/bus_sequencer.sv
// bus_sequencer: CPU phase enables, slow-cycle stretching, DMA bus handoff and WSYNC ready.
// Define BUS_SEQ_SLOW_CYCLE_EN to stretch cycles that target slow devices (TIA/RIOT).
module bus_sequencer #(
  parameter int FAST_DIV = 4,
  parameter int SLOW_DIV = 6
) (
  input  logic sysclock,
  input  logic reset_b,
  input  logic sel_slow_clock,
  input  logic deassert_ready,
  input  logic line_start,
  input  logic dma_req,
  input  logic dma_end,
  output logic pclk0,
  output logic pclk1,
  output logic halt_b,
  output logic ready,
  output logic drive_AB,
  output logic dma_grant
);
  typedef enum logic [1:0] {IDLE, HALT_WAIT, DMA, RELEASE} state_t;
  localparam logic [3:0] FAST_LEN = 4'(FAST_DIV);
  localparam logic [2:0] FAST_LAST = 3'(FAST_DIV - 1);
  state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [3:0] len_q, len_d, next_len;
  logic halt_b_q, drive_q, grant_q, ready_q, wrap, run;
`ifdef BUS_SEQ_SLOW_CYCLE_EN
  assign next_len = sel_slow_clock ? 4'(SLOW_DIV) : FAST_LEN;
`else
  logic unused_sel;
  assign unused_sel = sel_slow_clock;
  assign next_len = FAST_LEN;
`endif
  assign wrap = {1'b0, cnt_q} == len_q - 4'd1;
  assign run = state_q == IDLE || state_q == HALT_WAIT;
  assign pclk0 = run && cnt_q == 3'd0;
  assign pclk1 = run && {1'b0, cnt_q} == (len_q >> 1);
  assign halt_b = halt_b_q;
  assign drive_AB = drive_q;
  assign dma_grant = grant_q;
  assign ready = ready_q;
  always_comb begin
    state_d = state_q;
    cnt_d = wrap ? 3'd0 : cnt_q + 3'd1;
    len_d = wrap ? next_len : len_q;
    case (state_q)
      IDLE:      state_d = dma_req ? (wrap ? DMA : HALT_WAIT) : IDLE;
      HALT_WAIT: state_d = !dma_req ? IDLE : wrap ? DMA : HALT_WAIT;
      DMA:       state_d = dma_end ? RELEASE : DMA;
      default:   state_d = IDLE;
    endcase
    // Counter parks at the last fast tick while MARIA owns the bus, restarting at 0 on release
    if (state_d == DMA && state_q != DMA) begin
      cnt_d = FAST_LAST;
      len_d = FAST_LEN;
    end
    if (state_q == DMA) begin
      cnt_d = cnt_q;
      len_d = len_q;
    end
    if (state_q == RELEASE) begin
      cnt_d = 3'd0;
      len_d = next_len;
    end
  end
  always_ff @(posedge sysclock or negedge reset_b) begin
    if (!reset_b) begin
      state_q  <= IDLE;
      cnt_q    <= FAST_LAST;
      len_q    <= FAST_LEN;
      halt_b_q <= 1'b1;
      drive_q  <= 1'b0;
      grant_q  <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      halt_b_q <= state_d == IDLE;
      drive_q  <= state_d == DMA;
      grant_q  <= state_d == DMA && state_q != DMA;
      ready_q  <= !deassert_ready && (line_start || ready_q);
    end
  end
endmodule

// File: tb/tb_bus_sequencer.sv
// tb_bus_sequencer: directed checks of phase enables, stretching, DMA handoff, WSYNC and reset.
module tb_bus_sequencer;
  logic sysclock = 1'b0;
  logic reset_b = 1'b0;
  logic sel_slow_clock = 1'b0, deassert_ready = 1'b0, line_start = 1'b0;
  logic dma_req = 1'b0, dma_end = 1'b0;
  logic pclk0, pclk1, halt_b, ready, drive_AB, dma_grant;
  int checks = 0, errors = 0;
  bus_sequencer dut (
    .sysclock(sysclock), .reset_b(reset_b), .sel_slow_clock(sel_slow_clock),
    .deassert_ready(deassert_ready), .line_start(line_start), .dma_req(dma_req),
    .dma_end(dma_end), .pclk0(pclk0), .pclk1(pclk1), .halt_b(halt_b), .ready(ready),
    .drive_AB(drive_AB), .dma_grant(dma_grant)
  );
  always #5 sysclock = ~sysclock;
  task automatic check(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step;
    @(posedge sysclock);
    @(negedge sysclock);
  endtask
  task automatic sync_pclk0;
    int n = 0;
    while (!pclk0 && n < 16) begin
      step;
      n++;
    end
    check("sync_pclk0", pclk0, 1'b1);
  endtask
  initial begin
    @(negedge sysclock);
    @(negedge sysclock);
    check("rst_pclk0", pclk0, 1'b0);
    check("rst_pclk1", pclk1, 1'b0);
    check("rst_halt_b", halt_b, 1'b1);
    check("rst_ready", ready, 1'b1);
    check("rst_drive", drive_AB, 1'b0);
    check("rst_grant", dma_grant, 1'b0);
    reset_b = 1'b1;
    step;
    // free run: pclk0 every 4 ticks, pclk1 two ticks later
    for (int n = 0; n < 12; n++) begin
      check($sformatf("free_pclk0_%0d", n), pclk0, n % 4 == 0);
      check($sformatf("free_pclk1_%0d", n), pclk1, n % 4 == 2);
      check($sformatf("free_halt_%0d", n), halt_b, 1'b1);
      step;
    end
    // slow stretch: sel high across one wrap
    step; step; step;
    sel_slow_clock = 1'b1;
    step;
    sel_slow_clock = 1'b0;
    for (int i = 0; i < 10; i++) begin
`ifdef BUS_SEQ_SLOW_CYCLE_EN
      check($sformatf("slow_pclk0_%0d", i), pclk0, i == 0 || i == 6);
      check($sformatf("slow_pclk1_%0d", i), pclk1, i == 3 || i == 8);
`else
      check($sformatf("slow_pclk0_%0d", i), pclk0, i % 4 == 0);
      check($sformatf("slow_pclk1_%0d", i), pclk1, i % 4 == 2);
`endif
      step;
    end
    // DMA grant with request seen at cnt=1
    sync_pclk0;
    step;
    dma_req = 1'b1;
    step;
    check("hw_halt_b", halt_b, 1'b0);
    check("hw_drive", drive_AB, 1'b0);
    check("hw_pclk1", pclk1, 1'b1);
    step;
    check("hw2_drive", drive_AB, 1'b0);
    check("hw2_grant", dma_grant, 1'b0);
    step;
    check("grant_drive", drive_AB, 1'b1);
    check("grant_pulse", dma_grant, 1'b1);
    check("grant_halt_b", halt_b, 1'b0);
    check("grant_pclk0", pclk0, 1'b0);
    dma_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step;
      check($sformatf("dma_grant_off_%0d", i), dma_grant, 1'b0);
      check($sformatf("dma_drive_%0d", i), drive_AB, 1'b1);
      check($sformatf("dma_pclk0_%0d", i), pclk0, 1'b0);
      check($sformatf("dma_pclk1_%0d", i), pclk1, 1'b0);
    end
    dma_end = 1'b1;
    step;
    dma_end = 1'b0;
    check("rel_drive", drive_AB, 1'b0);
    check("rel_halt_b", halt_b, 1'b0);
    check("rel_pclk0", pclk0, 1'b0);
    step;
    check("idle_halt_b", halt_b, 1'b1);
    check("idle_pclk0", pclk0, 1'b1);
    step; step;
    check("idle_pclk1", pclk1, 1'b1);
    // stray dma_end in IDLE is ignored
    dma_end = 1'b1;
    step;
    dma_end = 1'b0;
    check("stray_end_halt_b", halt_b, 1'b1);
    check("stray_end_drive", drive_AB, 1'b0);
    // request seen on the last tick of a cycle grants after one edge
    sync_pclk0;
    step; step; step;
    dma_req = 1'b1;
    step;
    dma_req = 1'b0;
    check("k3_drive", drive_AB, 1'b1);
    check("k3_grant", dma_grant, 1'b1);
    step;
    dma_end = 1'b1;
    step;
    dma_end = 1'b0;
    step;
    check("k3_pclk0", pclk0, 1'b1);
    // request withdrawn after one tick
    sync_pclk0;
    dma_req = 1'b1;
    step;
    dma_req = 1'b0;
    check("wd_halt_b_low", halt_b, 1'b0);
    check("wd_grant", dma_grant, 1'b0);
    step;
    check("wd_halt_b_high", halt_b, 1'b1);
    check("wd_pclk1", pclk1, 1'b1);
    check("wd_drive", drive_AB, 1'b0);
    step; step;
    check("wd_pclk0", pclk0, 1'b1);
    // WSYNC hold and release
    deassert_ready = 1'b1;
    step;
    deassert_ready = 1'b0;
    check("ws_ready_low", ready, 1'b0);
    step; step;
    check("ws_ready_held", ready, 1'b0);
    line_start = 1'b1;
    step;
    line_start = 1'b0;
    check("ws_ready_high", ready, 1'b1);
    deassert_ready = 1'b1;
    line_start = 1'b1;
    step;
    deassert_ready = 1'b0;
    line_start = 1'b0;
    check("ws_both_low", ready, 1'b0);
    step; step;
    check("ws_both_held", ready, 1'b0);
    line_start = 1'b1;
    step;
    line_start = 1'b0;
    check("ws_both_release", ready, 1'b1);
    // reset asserted while MARIA owns the bus
    sync_pclk0;
    step; step; step;
    dma_req = 1'b1;
    step;
    dma_req = 1'b0;
    check("rd_drive", drive_AB, 1'b1);
    reset_b = 1'b0;
    #1;
    check("rd_drive_async", drive_AB, 1'b0);
    check("rd_halt_b_async", halt_b, 1'b1);
    @(negedge sysclock);
    reset_b = 1'b1;
    step;
    check("rd_pclk0", pclk0, 1'b1);
    check("rd_halt_b", halt_b, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
